// File: rtl/cmac_link_manager.sv
// CMAC RX link bring-up: reset sequencing, alignment debounce and packet-aligned RX gating.
// Build option: define CMAC_LINK_STATS_EN for live reset_count / link_drop_count counters.
module cmac_link_manager #(
    parameter int RSFEC                = 1,
    parameter int DATA_WIDTH           = 512,
    parameter int RESET_CYCLES         = 50,
    parameter int ALIGN_TIMEOUT_CYCLES = 644531250,
    parameter int STABLE_CYCLES        = 1024,
    parameter int SILENCE_CYCLES       = 322265
) (
    input  logic                    rx_clk,
    input  logic                    rx_resetn,
    input  logic                    reset_req,
    input  logic                    stat_rx_aligned,
    output logic                    sys_reset_out,
    output logic                    ctl_rx_enable,
    output logic                    ctl_tx_enable,
    output logic                    ctl_tx_send_rfi,
    output logic                    ctl_rx_rsfec_enable,
    output logic                    ctl_rx_rsfec_enable_correction,
    output logic                    ctl_rx_rsfec_enable_indication,
    output logic                    ctl_tx_rsfec_enable,
    input  logic [DATA_WIDTH-1:0]   rx_in_tdata,
    input  logic [DATA_WIDTH/8-1:0] rx_in_tkeep,
    input  logic                    rx_in_tlast,
    input  logic                    rx_in_tuser,
    input  logic                    rx_in_tvalid,
    output logic [DATA_WIDTH-1:0]   rx_out_tdata,
    output logic [DATA_WIDTH/8-1:0] rx_out_tkeep,
    output logic                    rx_out_tlast,
    output logic                    rx_out_tuser,
    output logic                    rx_out_tvalid,
    output logic                    link_up,
    output logic [15:0]             reset_count,
    output logic [15:0]             link_drop_count,
    output logic [1:0]              dbg_state
);
    localparam int RST_W = $clog2(RESET_CYCLES + 1);
    localparam int ALN_W = $clog2(ALIGN_TIMEOUT_CYCLES + 1);
    localparam int STB_W = $clog2(STABLE_CYCLES + 1);
    localparam int SIL_W = $clog2(SILENCE_CYCLES + 1);
    localparam logic [RST_W-1:0] RST_LOAD = RST_W'(RESET_CYCLES);
    localparam logic [ALN_W-1:0] ALN_LOAD = ALN_W'(ALIGN_TIMEOUT_CYCLES);
    localparam logic [SIL_W-1:0] SIL_LOAD = SIL_W'(SILENCE_CYCLES);
    // The aligned cycle seen in WAIT_ALIGN is the first of the stable run.
    localparam logic [STB_W-1:0] STB_LAST = STB_W'((STABLE_CYCLES > 1) ? STABLE_CYCLES - 2 : 0);

    typedef enum logic [1:0] {
        ST_RESET      = 2'd0,
        ST_WAIT_ALIGN = 2'd1,
        ST_DEBOUNCE   = 2'd2,
        ST_UP         = 2'd3
    } state_t;

    state_t           state;
    logic [2:0]       sync_q;
    logic [RST_W-1:0] reset_timer;
    logic [ALN_W-1:0] align_timer;
    logic [STB_W-1:0] stable_cnt;
    logic [SIL_W-1:0] silence_timer;
    logic             pass_q;
    logic             sof_q;
    logic             aligned;
    logic             enter_reset;
    logic             pass;

    assign aligned = sync_q[2];

    assign enter_reset = reset_req
                       || ((state == ST_WAIT_ALIGN) && !aligned && (align_timer <= ALN_W'(1)))
                       || ((state == ST_UP) && !aligned);

    // axis_rx has no tready: a beat transfers on every cycle where tvalid is high.
    assign pass = (state == ST_UP) && (pass_q || ((silence_timer == '0) && sof_q));

    always_ff @(posedge rx_clk or negedge rx_resetn) begin
        if (!rx_resetn) begin
            state         <= ST_RESET;
            sync_q        <= '0;
            reset_timer   <= RST_LOAD;
            align_timer   <= '0;
            stable_cnt    <= '0;
            silence_timer <= SIL_LOAD;
            pass_q        <= 1'b0;
            sof_q         <= 1'b1;
        end else begin
            sync_q <= {sync_q[1:0], stat_rx_aligned};
            pass_q <= pass;
            if (rx_in_tvalid) sof_q <= rx_in_tlast;

            if (enter_reset) silence_timer <= SIL_LOAD;
            else if (silence_timer != '0) silence_timer <= silence_timer - SIL_W'(1);

            if (enter_reset) begin
                state       <= ST_RESET;
                reset_timer <= RST_LOAD;
            end else begin
                case (state)
                    ST_RESET: begin
                        if (reset_timer <= RST_W'(1)) begin
                            state       <= ST_WAIT_ALIGN;
                            align_timer <= ALN_LOAD;
                        end else begin
                            reset_timer <= reset_timer - RST_W'(1);
                        end
                    end
                    ST_WAIT_ALIGN: begin
                        if (aligned) begin
                            state      <= ST_DEBOUNCE;
                            stable_cnt <= '0;
                        end else begin
                            align_timer <= align_timer - ALN_W'(1);
                        end
                    end
                    ST_DEBOUNCE: begin
                        // Falling back keeps the remaining alignment budget.
                        if (!aligned) state <= ST_WAIT_ALIGN;
                        else if (stable_cnt >= STB_LAST) state <= ST_UP;
                        else stable_cnt <= stable_cnt + STB_W'(1);
                    end
                    default: state <= ST_UP;
                endcase
            end
        end
    end

    assign sys_reset_out   = (state == ST_RESET);
    assign link_up         = (state == ST_UP);
    assign dbg_state       = state;
    assign ctl_rx_enable   = 1'b1;
    assign ctl_tx_enable   = link_up;
    assign ctl_tx_send_rfi = !link_up;

    assign ctl_rx_rsfec_enable            = (RSFEC != 0);
    assign ctl_rx_rsfec_enable_correction = (RSFEC != 0);
    assign ctl_rx_rsfec_enable_indication = (RSFEC != 0);
    assign ctl_tx_rsfec_enable            = (RSFEC != 0);

    assign rx_out_tdata  = rx_in_tdata;
    assign rx_out_tkeep  = rx_in_tkeep;
    assign rx_out_tlast  = rx_in_tlast;
    assign rx_out_tuser  = rx_in_tuser;
    assign rx_out_tvalid = rx_in_tvalid & pass;

`ifdef CMAC_LINK_STATS_EN
    logic [15:0] reset_cnt_q;
    logic [15:0] drop_cnt_q;

    always_ff @(posedge rx_clk or negedge rx_resetn) begin
        if (!rx_resetn) begin
            reset_cnt_q <= '0;
            drop_cnt_q  <= '0;
        end else if (enter_reset) begin
            if (reset_cnt_q != 16'hFFFF) reset_cnt_q <= reset_cnt_q + 16'd1;
            if ((state == ST_UP) && (drop_cnt_q != 16'hFFFF)) drop_cnt_q <= drop_cnt_q + 16'd1;
        end
    end

    assign reset_count     = reset_cnt_q;
    assign link_drop_count = drop_cnt_q;
`else
    assign reset_count     = '0;
    assign link_drop_count = '0;
`endif

endmodule

// File: tb/tb_cmac_link_manager.sv
// Randomized bench for cmac_link_manager against a behavioural link/gating model.
module tb_cmac_link_manager;
    localparam int DW  = 64;
    localparam int RC  = 4;
    localparam int AT  = 100;
    localparam int SC  = 8;
    localparam int SIL = 20;
`ifdef CMAC_LINK_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic            rx_clk = 1'b0;
    logic            rx_resetn = 1'b1;
    logic            reset_req = 1'b0;
    logic            stat_rx_aligned = 1'b0;
    logic            sys_reset_out, ctl_rx_enable, ctl_tx_enable, ctl_tx_send_rfi;
    logic            rs0, rs1, rs2, rs3;
    logic [DW-1:0]   rx_in_tdata = '0;
    logic [DW/8-1:0] rx_in_tkeep = '0;
    logic            rx_in_tlast = 1'b0, rx_in_tuser = 1'b0, rx_in_tvalid = 1'b0;
    logic [DW-1:0]   rx_out_tdata;
    logic [DW/8-1:0] rx_out_tkeep;
    logic            rx_out_tlast, rx_out_tuser, rx_out_tvalid, link_up;
    logic [15:0]     reset_count, link_drop_count;
    logic [1:0]      dbg_state;

    cmac_link_manager #(
        .RSFEC(1), .DATA_WIDTH(DW), .RESET_CYCLES(RC), .ALIGN_TIMEOUT_CYCLES(AT),
        .STABLE_CYCLES(SC), .SILENCE_CYCLES(SIL)
    ) dut (
        .rx_clk(rx_clk), .rx_resetn(rx_resetn), .reset_req(reset_req),
        .stat_rx_aligned(stat_rx_aligned), .sys_reset_out(sys_reset_out),
        .ctl_rx_enable(ctl_rx_enable), .ctl_tx_enable(ctl_tx_enable),
        .ctl_tx_send_rfi(ctl_tx_send_rfi), .ctl_rx_rsfec_enable(rs0),
        .ctl_rx_rsfec_enable_correction(rs1), .ctl_rx_rsfec_enable_indication(rs2),
        .ctl_tx_rsfec_enable(rs3), .rx_in_tdata(rx_in_tdata), .rx_in_tkeep(rx_in_tkeep),
        .rx_in_tlast(rx_in_tlast), .rx_in_tuser(rx_in_tuser), .rx_in_tvalid(rx_in_tvalid),
        .rx_out_tdata(rx_out_tdata), .rx_out_tkeep(rx_out_tkeep), .rx_out_tlast(rx_out_tlast),
        .rx_out_tuser(rx_out_tuser), .rx_out_tvalid(rx_out_tvalid), .link_up(link_up),
        .reset_count(reset_count), .link_drop_count(link_drop_count), .dbg_state(dbg_state)
    );

    // Clock
    always #5 rx_clk = ~rx_clk;

    int errors = 0;
    int checks = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: reset pulse remaining, alignment budget used, aligned run length.
    int            m_rst_left, m_wait_used, m_run, m_silence, m_resets, m_drops;
    bit            m_up, m_sof, m_gate;
    bit [2:0]      m_al_hist;
    logic [DW-1:0] exp_q[$];

    function automatic void model_init();
        m_rst_left = RC;  m_wait_used = 0; m_run = 0; m_silence = SIL;
        m_resets = 0;     m_drops = 0;     m_up = 1'b0; m_sof = 1'b1;
        m_gate = 1'b0;    m_al_hist = '0;
    endfunction

    function automatic bit model_pass();
        return m_up && (m_gate || (m_silence == 0 && m_sof));
    endfunction

    always @(posedge rx_clk) begin : model_step
        bit al, p, entered;
        if (!rx_resetn) begin
            model_init();
        end else begin
            al = m_al_hist[2];
            p = model_pass();
            entered = 1'b0;
            if (reset_req) entered = 1'b1;
            else if (m_rst_left > 0) begin
                m_rst_left--;
                if (m_rst_left == 0) begin m_wait_used = 0; m_run = 0; end
            end else if (m_up) begin
                if (!al) entered = 1'b1;
            end else if (al) begin
                m_run++;
                if (m_run >= SC) m_up = 1'b1;
            end else if (m_run > 0) m_run = 0;
            else begin
                m_wait_used++;
                if (m_wait_used >= AT) entered = 1'b1;
            end
            if (entered) begin
                if (m_up && m_drops < 65535) m_drops++;
                if (m_resets < 65535) m_resets++;
                m_up = 1'b0; m_rst_left = RC; m_run = 0; m_silence = SIL;
            end else if (m_silence > 0) m_silence--;
            m_gate = p;
            if (rx_in_tvalid) m_sof = rx_in_tlast;
            m_al_hist = {m_al_hist[1:0], stat_rx_aligned};
        end
    end

    // Scoreboard at the falling edge
    int            rst_hi_cnt = 0;
    int            out_beats = 0;
    logic [DW-1:0] first_out = '0;

    always @(negedge rx_clk) begin : scoreboard
        bit exp_v;
        if ($time > 2) begin
            check_eq("sys_reset_out", sys_reset_out, m_rst_left > 0);
            check_eq("link_up", link_up, m_up);
            check_eq("ctl_tx_enable", ctl_tx_enable, m_up);
            check_eq("ctl_tx_send_rfi", ctl_tx_send_rfi, !m_up);
            check_eq("ctl_rx_enable", ctl_rx_enable, 1);
            check_eq("rsfec", {rs0, rs1, rs2, rs3}, 4'hF);
            check_eq("reset_count", reset_count, STATS ? m_resets : 0);
            check_eq("link_drop_count", link_drop_count, STATS ? m_drops : 0);
            exp_v = rx_in_tvalid && model_pass();
            check_eq("rx_out_tvalid", rx_out_tvalid, exp_v);
            check_eq("rx_out_side", {rx_out_tkeep, rx_out_tlast, rx_out_tuser},
                     {rx_in_tkeep, rx_in_tlast, rx_in_tuser});
            if (exp_v) exp_q.push_back(rx_in_tdata);
            if (rx_out_tvalid) begin
                if (exp_q.size() == 0) check_eq("unexpected_beat", 1, 0);
                else check_eq("beat_data", rx_out_tdata, exp_q.pop_front());
                out_beats++;
                if (out_beats == 1) first_out = rx_out_tdata;
            end
            if (sys_reset_out) rst_hi_cnt++;
        end
    end

    // Driver tasks
    task automatic tick(input int n);
        repeat (n) begin @(posedge rx_clk); #1; end
    endtask

    task automatic send_packet(input int len, output logic [DW-1:0] first);
        for (int i = 0; i < len; i++) begin
            rx_in_tdata  = {$urandom, $urandom};
            rx_in_tkeep  = DW/8'($urandom);
            rx_in_tuser  = 1'($urandom_range(0, 1));
            rx_in_tlast  = (i == len - 1);
            rx_in_tvalid = 1'b1;
            if (i == 0) first = rx_in_tdata;
            tick(1);
        end
        rx_in_tvalid = 1'b0;
        rx_in_tlast  = 1'b0;
    endtask

    initial begin
        logic [DW-1:0] first_a, first_b;
        logic [15:0]   snap_rst, snap_drop;
        int            n;
        model_init();
        #1 rx_resetn = 1'b0;
        repeat (3) @(posedge rx_clk);
        #1;
        rx_resetn = 1'b1;
        rst_hi_cnt = 0;

        // No alignment: periodic 4-cycle reset pulses every 104 cycles
        tick(320);
        check_eq("timeout_pulse_cycles", rst_hi_cnt, 16);
        check_eq("timeout_reset_count", reset_count, STATS ? 3 : 0);

        // Bouncing alignment then steady: link up 3 sync + 8 stable cycles after final rise
        stat_rx_aligned = 1'b1; tick(5);
        stat_rx_aligned = 1'b0; tick(1);
        stat_rx_aligned = 1'b1;
        n = 0;
        while (!link_up && n < 40) begin tick(1); n++; end
        check_eq("link_up_latency", n, 11);

        // Silence expires on beat 2 of a 4-beat packet
        snap_rst = reset_count;
        reset_req = 1'b1; tick(1);
        reset_req = 1'b0; out_beats = 0;
        tick(19);
        send_packet(4, first_a);
        send_packet(3, first_b);
        tick(5);
        check_eq("silence_out_beats", out_beats, 3);
        check_eq("silence_first_beat", first_out, first_b);
        check_eq("silence_reset_count", reset_count - snap_rst, STATS ? 1 : 0);

        // Alignment drop while UP
        snap_drop = link_drop_count;
        check_eq("pre_drop_link_up", link_up, 1);
        stat_rx_aligned = 1'b0; tick(4);
        rst_hi_cnt = 0; out_beats = 0;
        for (int k = 0; k < 6; k++) begin
            send_packet($urandom_range(1, 4), first_a);
            tick(1);
        end
        check_eq("drop_pulse_cycles", rst_hi_cnt, 4);
        check_eq("drop_out_beats", out_beats, 0);
        check_eq("drop_count", link_drop_count - snap_drop, STATS ? 1 : 0);

        // Two reset requests: one in UP, one in the second RESET cycle
        stat_rx_aligned = 1'b1;
        n = 0;
        while (!link_up && n < 200) begin tick(1); n++; end
        check_eq("relink_up", link_up, 1);
        snap_rst = reset_count;
        reset_req = 1'b1; tick(1);
        reset_req = 1'b0; rst_hi_cnt = 0; tick(1);
        reset_req = 1'b1; tick(1);
        reset_req = 1'b0; tick(20);
        check_eq("req_pulse_cycles", rst_hi_cnt, 6);
        check_eq("req_reset_count", reset_count - snap_rst, STATS ? 2 : 0);

        // Random traffic, alignment flaps and reset requests
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 39) == 0) stat_rx_aligned = ~stat_rx_aligned;
            reset_req    = ($urandom_range(0, 199) == 0);
            rx_in_tvalid = ($urandom_range(0, 9) < 7);
            rx_in_tlast  = ($urandom_range(0, 3) == 0);
            rx_in_tuser  = 1'($urandom_range(0, 1));
            rx_in_tkeep  = DW/8'($urandom);
            rx_in_tdata  = {$urandom, $urandom};
            tick(1);
        end
        reset_req = 1'b0; rx_in_tvalid = 1'b0;
        tick(2);
        check_eq("scoreboard_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/cmac_link_manager.md
CMAC_LINK_MANAGER -- requirements
Module: cmac_link_manager

Interface
REQ-001 Parameter RSFEC, default 1: drives all four RS-FEC enable outputs.
REQ-002 Parameter DATA_WIDTH, default 512: AXI-Stream tdata width, multiple of 8; tkeep width is DATA_WIDTH/8.
REQ-003 Parameter RESET_CYCLES, default 50: cycles sys_reset_out is held per reset.
REQ-004 Parameter ALIGN_TIMEOUT_CYCLES, default 644531250 (2 s at 322265625 Hz): maximum wait for alignment.
REQ-005 Parameter STABLE_CYCLES, default 1024: consecutive aligned cycles required before link-up.
REQ-006 Parameter SILENCE_CYCLES, default 322265 (1 ms): RX gating time after each reset.
REQ-007 rx_clk  in  1  sole clock.
REQ-008 rx_resetn  in  1  asynchronous, active-low reset.
REQ-009 reset_req  in  1  synchronous request pulse; forces a CMAC reset.
REQ-010 stat_rx_aligned  in  1  CMAC PCS alignment; asynchronous to rx_clk.
REQ-011 sys_reset_out  out  1  CMAC RX transceiver reset, active-high.
REQ-012 ctl_rx_enable, ctl_tx_enable, ctl_tx_send_rfi  out  1 each  CMAC control.
REQ-013 ctl_rx_rsfec_enable, ctl_rx_rsfec_enable_correction, ctl_rx_rsfec_enable_indication, ctl_tx_rsfec_enable  out  1 each  tied to RSFEC.
REQ-014 rx_in_tdata/tkeep/tlast/tuser/tvalid  in  DATA_WIDTH/DATA_WIDTH/8/1/1/1  CMAC axis_rx.
REQ-015 rx_out_tdata/tkeep/tlast/tuser/tvalid  out  same widths  gated axis_rx.
REQ-016 link_up  out  1  high only in state UP.
REQ-017 reset_count  out  16  CMAC resets issued (stats build only).
REQ-018 link_drop_count  out  16  UP-to-reset transitions (stats build only).

Function
REQ-019 stat_rx_aligned shall pass through a 3-FF synchronizer; "aligned" below means the synchronized value.
REQ-020 FSM states: RESET, WAIT_ALIGN, DEBOUNCE, UP.
REQ-021 RESET: sys_reset_out=1 for exactly RESET_CYCLES cycles, then WAIT_ALIGN with the align timer loaded to ALIGN_TIMEOUT_CYCLES.
REQ-022 WAIT_ALIGN: aligned -> DEBOUNCE, stable counter cleared; timer expiry (counted to 0) -> RESET.
REQ-023 DEBOUNCE: aligned low -> WAIT_ALIGN without reloading the align timer; STABLE_CYCLES consecutive aligned cycles -> UP.
REQ-024 UP: aligned low -> RESET, link_drop_count incremented.
REQ-025 reset_req high in any state -> RESET next cycle; takes priority over all other transitions; retriggers RESET_CYCLES if already in RESET.
REQ-026 Every entry to RESET shall load the silence timer with SILENCE_CYCLES and increment reset_count.
REQ-027 ctl_rx_enable=1; ctl_tx_enable=link_up; ctl_tx_send_rfi=~link_up.
REQ-028 rx_out data, keep, last and user shall equal the inputs combinationally, with zero latency.
REQ-029 rx_out_tvalid = rx_in_tvalid & pass; pass is set only when the silence timer is 0, state is UP, and the current beat is the first beat of a packet.
REQ-030 Packet-boundary tracking: a beat is first-of-packet if no beat was seen since reset or the previous valid beat had tlast=1.
REQ-031 pass shall clear when state leaves UP; a packet in flight at that moment is truncated and no tlast is synthesized.
REQ-032 Counters shall saturate at 0xFFFF and never wrap.
REQ-033 All timers shall be wide enough for their parameter, computed with $clog2.

Reset
REQ-034 On rx_resetn low: state=RESET, reset timer=RESET_CYCLES, silence timer=SILENCE_CYCLES, pass=0, first-of-packet=1, counters=0, synchronizer FFs=0.
REQ-035 During rx_resetn low: sys_reset_out=1, link_up=0, ctl_tx_enable=0, ctl_tx_send_rfi=1, rx_out_tvalid=0.
REQ-036 The first entry to RESET after rx_resetn release shall not increment reset_count.

Configuration
REQ-037 With macro CMAC_LINK_STATS_EN defined, reset_count and link_drop_count shall be live per REQ-017/018/026/032.
REQ-038 Without CMAC_LINK_STATS_EN, both ports shall remain and be driven constant 0, and no counter flops shall exist.

Verification
REQ-039 Test parameters: RESET_CYCLES=4, ALIGN_TIMEOUT_CYCLES=100, STABLE_CYCLES=8, SILENCE_CYCLES=20.
REQ-040 Aligned never asserts -> sys_reset_out pulses 4 cycles wide, recurring every 4+100 cycles (± sync latency); reset_count increments on each pulse.
REQ-041 Aligned high for 5 cycles, low for 1, then high steadily -> link_up rises exactly 8 cycles after the final rise is synchronized.
REQ-042 Link UP, then aligned dropped -> link_drop_count=1, sys_reset_out high 4 cycles, rx_out_tvalid=0 for at least 20 cycles.
REQ-043 Silence expires mid-packet (beats 2 of 4 onward) -> remainder suppressed; next packet passes intact from its first beat.
REQ-044 reset_req pulse in UP, plus a second reset_req 2 cycles into RESET -> sys_reset_out stays high 6 cycles total; reset_count +2.
